cache_port_arbiter: RTL and testbench
=====================================

Name: cache_port_arbiter

Overview:
Round-robin arbiter that shares the single cache request port among NUM_REQ requesters.
It produces the one-hot select for the request-side one-hot data mux and sequences each transaction through issue and response.
It routes the response strobe back to the owning requester.
It handles control only; address and data bundles pass through the external one-hot mux under control of `grant`.

Parameters:
NUM_REQ, 4, number of requesters (≥2); width of all per-requester vectors
TIMEOUT, 64, max cycles spent in WAIT before the transaction is abandoned (≥2)
CNT_BITS, 7, width of the timeout counter; must hold TIMEOUT

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request; held high until matching req_ready
req_ready  out  NUM_REQ  one-hot, 1-cycle acceptance strobe to owner
grant  out  NUM_REQ  one-hot owner select, drives the one-hot mux `sel`; all-zero when idle
cache_valid  out  1  request valid to cache port
cache_ready  in  1  cache accepts request this cycle
cache_resp_valid  in  1  cache response strobe
resp_valid  out  NUM_REQ  one-hot, 1-cycle response strobe to owner
timeout_err  out  1  1-cycle pulse when WAIT times out
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values:
  - state=IDLE, grant=0, rr_ptr=0, wait counter=0.
  - cache_valid, req_ready, resp_valid, timeout_err and busy are all 0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid is set, select the first set bit scanning upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - Register the winner as one-hot `grant` and go to ISSUE.
  - If no req_valid is set, stay in IDLE.
  - grant=0 throughout IDLE.
- ISSUE:
  - cache_valid=1; grant is held stable.
  - When cache_ready=1: req_ready=grant in that same cycle (combinational from state and cache_ready), counter cleared, next state WAIT.
  - When cache_ready=0: remain in ISSUE indefinitely. No timeout applies in ISSUE.
- WAIT:
  - cache_valid=0; grant is held so the response path stays steered to the owner.
  - The counter increments every cycle.
  - On cache_resp_valid=1: resp_valid=grant in the same cycle, rr_ptr = owner index + 1 (mod NUM_REQ), next state IDLE.
  - When counter reaches TIMEOUT-1 without a response: timeout_err=1 for that cycle, rr_ptr advanced as above, next state IDLE. resp_valid stays 0.
  - If cache_resp_valid coincides with the final timeout cycle, the response wins: resp_valid is asserted and timeout_err is not.
- Latency:
  - req_valid seen in IDLE at cycle N gives grant/cache_valid at N+1.
  - Earliest req_ready is at N+1.
  - Earliest resp_valid is at N+2.
  - After a response at cycle M, the next grant is possible at M+2 (one IDLE cycle).
- req_valid is sampled only in IDLE. A requester dropping req_valid after grant does not abort the transaction.
- cache_resp_valid outside WAIT is ignored and produces no output.
- cache_ready outside ISSUE is ignored.
- At most one transaction is outstanding at any time.
- Fairness: a requester that keeps req_valid asserted is granted within NUM_REQ transactions.
- Reset in ISSUE or WAIT:
  - Returns to IDLE next edge with grant=0 and rr_ptr=0.
  - Any late response arriving afterwards is ignored.
- Invariant: grant, req_ready and resp_valid are always zero or one-hot, never multi-hot.

Test Plan:
- Single request: req_valid=4'b0100 at cycle 1 → grant=4'b0100, cache_valid=1 at cycle 2. cache_ready=1 at cycle 2 → req_ready=4'b0100 at cycle 2. cache_resp_valid at cycle 5 → resp_valid=4'b0100 at cycle 5, busy=0 at cycle 6.
- Round-robin: req_valid=4'b1111 held, cache ready and responding every opportunity → grant sequence 0001, 0010, 0100, 1000, 0001.
- Pointer resume: after a transaction granted to requester 2, req_valid=4'b1001 → grant=4'b1000 first, then 4'b0001.
- Backpressure: cache_ready=0 for 5 cycles in ISSUE → grant and cache_valid stable all 5 cycles, req_ready=0. cache_ready=1 on cycle 6 → exactly one req_ready pulse.
- Timeout: TIMEOUT=8, no cache_resp_valid → timeout_err pulses on the 8th WAIT cycle, resp_valid stays 0, then IDLE. A late cache_resp_valid after that produces no resp_valid.
- Reset in WAIT: reset asserted for 1 cycle during WAIT → grant=0, busy=0 next cycle. A subsequent req_valid=4'b0010 is granted 4'b0010 (rr_ptr=0 scan).

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache request port among NUM_REQ requesters.
// Sequences each transaction IDLE -> ISSUE -> WAIT and steers strobes back to the owner.
module cache_port_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int TIMEOUT  = 64,
    parameter int CNT_BITS = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [NUM_REQ-1:0] grant,
    output logic               cache_valid,
    input  logic               cache_ready,
    input  logic               cache_resp_valid,
    output logic [NUM_REQ-1:0] resp_valid,
    output logic               timeout_err,
    output logic               busy
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [PTR_W-1:0]    owner_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [CNT_BITS-1:0] cnt_q;

    logic [PTR_W-1:0]    pick_idx;
    logic                pick_found;
    logic [PTR_W-1:0]    ptr_next;
    logic                timeout_hit;

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        int j;
        j          = 0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!pick_found && req_valid[j]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(j);
            end
        end
    end

    assign ptr_next    = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
    // A response in the final wait cycle takes priority over the timeout.
    assign timeout_hit = (state_q == WAIT) && !cache_resp_valid &&
                         (cnt_q == CNT_BITS'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= NUM_REQ'(1) << pick_idx;
                        owner_q <= pick_idx;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cache_ready) begin
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + CNT_BITS'(1);
                    if (cache_resp_valid || timeout_hit) begin
                        rr_ptr_q <= ptr_next;
                        grant_q  <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign cache_valid = (state_q == ISSUE);
    assign req_ready   = (state_q == ISSUE && cache_ready) ? grant_q : '0;
    assign resp_valid  = (state_q == WAIT && cache_resp_valid) ? grant_q : '0;
    assign timeout_err = timeout_hit;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: directed transactions push expected
// grant/ready/response/timeout events; a negedge monitor pops and compares them.
module tb_cache_port_arbiter;
    localparam int NR = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [NR-1:0] grant;
    logic          cache_valid;
    logic          cache_ready;
    logic          cache_resp_valid;
    logic [NR-1:0] resp_valid;
    logic          timeout_err;
    logic          busy;

    cache_port_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO), .CNT_BITS(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .grant            (grant),
        .cache_valid      (cache_valid),
        .cache_ready      (cache_ready),
        .cache_resp_valid (cache_resp_valid),
        .resp_valid       (resp_valid),
        .timeout_err      (timeout_err),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    localparam int EV_GRANT = 0, EV_RDY = 1, EV_RESP = 2, EV_TMO = 3;
    typedef struct {
        int            kind;
        logic [NR-1:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    logic cv_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int kind, input logic [NR-1:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input logic [NR-1:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind %0d val %b at %0t", kind, val, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                errors++;
                $display("FAIL event got kind %0d val %b want kind %0d val %b at %0t",
                         kind, val, e.kind, e.val, $time);
            end
        end
    endtask

    // Monitor: decoupled from stimulus, sees only DUT outputs.
    always @(negedge clk) begin
        if (!reset) begin
            check("onehot", {29'd0, $onehot0(grant), $onehot0(req_ready), $onehot0(resp_valid)}, 32'h7);
            if (cache_valid && !cv_prev) pop_cmp(EV_GRANT, grant);
            if (|req_ready)              pop_cmp(EV_RDY, req_ready);
            if (|resp_valid)             pop_cmp(EV_RESP, resp_valid);
            if (timeout_err)             pop_cmp(EV_TMO, '0);
        end
        cv_prev = cache_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // resp_wait >= 0: response after that many empty WAIT cycles
    // resp_wait == -1: let it time out; -2: reset while in WAIT
    task automatic txn(input logic [NR-1:0] req, input logic [NR-1:0] g,
                       input int rdy_wait, input int resp_wait);
        push(EV_GRANT, g);
        push(EV_RDY, g);
        if (resp_wait >= 0)       push(EV_RESP, g);
        else if (resp_wait == -1) push(EV_TMO, '0);
        req_valid = req;
        step();
        for (int k = 0; k < rdy_wait; k++) begin
            cache_ready = 1'b0;
            @(negedge clk);
            check("bp_grant", {28'd0, grant}, {28'd0, g});
            check("bp_cvalid_rdy", {30'd0, cache_valid, |req_ready}, 32'h2);
            step();
        end
        cache_ready = 1'b1;
        step();
        cache_ready = 1'b0;
        req_valid   = req_valid & ~g;
        if (resp_wait >= 0) begin
            repeat (resp_wait) step();
            cache_resp_valid = 1'b1;
            @(negedge clk);
            check("busy_at_resp", {31'd0, busy}, 32'd1);
            step();
            cache_resp_valid = 1'b0;
            @(negedge clk);
            check("idle_after_resp", {27'd0, busy, grant}, 32'd0);
        end else if (resp_wait == -1) begin
            for (int k = 0; k < TO; k++) begin
                @(negedge clk);
                check("timeout_err", {31'd0, timeout_err}, {31'd0, (k == TO - 1)});
                step();
            end
            @(negedge clk);
            check("idle_after_tmo", {27'd0, busy, grant}, 32'd0);
            step();
            cache_resp_valid = 1'b1;
            @(negedge clk);
            check("late_resp", {28'd0, resp_valid}, 32'd0);
            step();
            cache_resp_valid = 1'b0;
        end else begin
            step();
            step();
            reset = 1'b1;
            step();
            reset = 1'b0;
            @(negedge clk);
            check("reset_in_wait", {27'd0, busy, grant}, 32'd0);
            cache_resp_valid = 1'b1;
            step();
            cache_resp_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        req_valid        = '0;
        cache_ready      = 1'b0;
        cache_resp_valid = 1'b0;
        step();
        @(negedge clk);
        check("reset_outs", {19'd0, grant, req_ready, resp_valid, cache_valid},  32'd0);
        check("reset_flags", {30'd0, timeout_err, busy}, 32'd0);
        step();
        reset = 1'b0;
        step();

        // Round-robin with all requesters held
        txn(4'b1111, 4'b0001, 0, 0);
        txn(4'b1110, 4'b0010, 0, 0);
        txn(4'b1100, 4'b0100, 0, 0);
        txn(4'b1000, 4'b1000, 0, 0);
        txn(4'b1111, 4'b0001, 0, 0);
        req_valid = '0;
        step();
        // Single request, response after two empty WAIT cycles
        txn(4'b0100, 4'b0100, 0, 2);
        // Pointer resumes after requester 2
        txn(4'b1001, 4'b1000, 0, 0);
        txn(4'b0001, 4'b0001, 0, 0);
        // Backpressure for 5 cycles
        txn(4'b0010, 4'b0010, 5, 1);
        // Response coincides with final timeout cycle: response wins
        txn(4'b0001, 4'b0001, 0, TO - 1);
        // Timeout with a late response afterwards
        txn(4'b1000, 4'b1000, 0, -1);
        // Reset during WAIT, then pointer must restart at 0
        txn(4'b0001, 4'b0001, 0, -2);
        txn(4'b0011, 4'b0001, 0, 0);
        txn(4'b0010, 4'b0010, 0, 0);

        repeat (3) step();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
